// File: rtl/ws2812_pkg.sv
// Shared state encoding, 40 MHz timing defaults and the per-channel brightness scale for the WS2812 chain driver.
package ws2812_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_RES   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_FETCH = S_FETCH,
    ST_LOAD  = S_LOAD,
    ST_SEND  = S_SEND,
    ST_RES   = S_RES
  } state_e;

  localparam int DEF_NUM_LEDS = 12;
  localparam int DEF_T_BIT    = 50;
  localparam int DEF_T0H      = 16;
  localparam int DEF_T1H      = 32;
  localparam int DEF_T_RES    = 4000;

  localparam int GRB_W = 24;

  // (ch * (b+1)) >> 8 keeps b=255 an exact identity without a divider.
  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] bright);
    logic [8:0] mult;
    mult = {1'b0, bright} + 9'd1;
    return 8'(({8'd0, ch} * {7'd0, mult}) >> 8);
  endfunction

endpackage

// File: rtl/ws2812_chain_driver_if.sv
// Pixel-store read port: one-cycle read strobe plus address out, GRB word back one cycle later.
interface ws2812_chain_driver_if #(
  parameter int IDX_W = 4
);
  logic             pix_req;
  logic [IDX_W-1:0] pix_idx;
  logic [23:0]      pix_data;

  modport master (output pix_req, output pix_idx, input pix_data);
  modport slave  (input pix_req, input pix_idx, output pix_data);
endinterface

// File: rtl/ws2812_scale.sv
// Combinational GRB brightness scaler, zero latency, no flow control.
module ws2812_scale
  import ws2812_pkg::*;
(
  input  logic [GRB_W-1:0] grb_i,
  input  logic [7:0]       bright_i,
  output logic [GRB_W-1:0] grb_o
);

  assign grb_o = {scale_ch(grb_i[23:16], bright_i),
                  scale_ch(grb_i[15:8],  bright_i),
                  scale_ch(grb_i[7:0],   bright_i)};

endmodule

// File: rtl/ws2812_chain_driver.sv
// WS2812B chain serialiser: first led_dout rise 3 cycles after start, pixels prefetched one bit ahead.
// start is ignored while busy; the pixel store must answer exactly one cycle after pix_req.
module ws2812_chain_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 3,
  parameter int T_BIT    = DEF_T_BIT,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int T_RES    = DEF_T_RES
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         start,
  input  logic                         auto_refresh,
  input  logic [7:0]                   brightness,
  ws2812_chain_driver_if.master        pix,
  output logic                         led_dout,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int IDX_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CNT_W  = $clog2(T_BIT);
  localparam int RCNT_W = $clog2(T_RES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0]  T0H_C    = CNT_W'(T0H);
  localparam logic [CNT_W-1:0]  T1H_C    = CNT_W'(T1H);
  localparam logic [RCNT_W-1:0] RES_LAST = RCNT_W'(T_RES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_LEDS - 1);
  localparam logic [4:0]        BIT_LAST = 5'd23;
  localparam logic [4:0]        BIT_PRE  = 5'd22;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        bit_q;
  logic [RCNT_W-1:0] rcnt_q;
  logic [GRB_W-1:0]  shift_q;
  logic [GRB_W-1:0]  shadow_q;
  logic              shadow_vld_q;
  logic [7:0]        bright_q;
  logic              pix_req_q;
  logic [IDX_W-1:0]  pix_idx_q;
  logic              cap_q;
  logic              led_dout_q;
  logic              busy_q;
  logic              frame_done_q;

  logic [CNT_W-1:0]  cnt_d;
  logic [RCNT_W-1:0] rcnt_d;
  logic [CNT_W-1:0]  hi_len;
  logic [GRB_W-1:0]  scaled;

  assign cnt_d  = cnt_q + CNT_W'(1);
  assign rcnt_d = rcnt_q + RCNT_W'(1);
  assign hi_len = shift_q[23] ? T1H_C : T0H_C;

  // Single scaler serves both the LOAD path and the prefetch-to-shadow path.
  ws2812_scale u_scale (
    .grb_i    (pix.pix_data),
    .bright_i (bright_q),
    .grb_o    (scaled)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      rcnt_q       <= '0;
      shift_q      <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      bright_q     <= '0;
      pix_req_q    <= 1'b0;
      pix_idx_q    <= '0;
      cap_q        <= 1'b0;
      led_dout_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pix_req_q    <= 1'b0;
      cap_q        <= pix_req_q;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          led_dout_q <= 1'b0;
          if (start) begin
            state_q   <= ST_FETCH;
            busy_q    <= 1'b1;
            bright_q  <= brightness;
            pix_req_q <= 1'b1;
            pix_idx_q <= '0;
          end
        end
        ST_FETCH: begin
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          shift_q      <= scaled;
          shadow_vld_q <= 1'b0;
          cnt_q        <= '0;
          bit_q        <= '0;
          led_dout_q   <= 1'b1;
          state_q      <= ST_SEND;
        end
        ST_SEND: begin
          if (cap_q) begin
            shadow_q     <= scaled;
            shadow_vld_q <= 1'b1;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bit_q == BIT_LAST) begin
              bit_q <= '0;
              if (shadow_vld_q) begin
                shift_q      <= shadow_q;
                shadow_vld_q <= 1'b0;
                led_dout_q   <= 1'b1;
              end else begin
                state_q      <= ST_RES;
                rcnt_q       <= '0;
                led_dout_q   <= 1'b0;
                frame_done_q <= (T_RES == 1);
              end
            end else begin
              bit_q      <= bit_q + 5'd1;
              shift_q    <= {shift_q[22:0], 1'b0};
              led_dout_q <= 1'b1;
              // Entering the last bit of a pixel: fetch the next one so it is ready at the boundary.
              if (bit_q == BIT_PRE && pix_idx_q != IDX_LAST) begin
                pix_req_q <= 1'b1;
                pix_idx_q <= pix_idx_q + IDX_W'(1);
              end
            end
          end else begin
            cnt_q      <= cnt_d;
            led_dout_q <= (cnt_d < hi_len);
          end
        end
        ST_RES: begin
          led_dout_q <= 1'b0;
          if (rcnt_q == RES_LAST) begin
            if (auto_refresh) begin
              state_q   <= ST_FETCH;
              bright_q  <= brightness;
              pix_req_q <= 1'b1;
              pix_idx_q <= '0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            rcnt_q       <= rcnt_d;
            frame_done_q <= (rcnt_d == RES_LAST);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pix.pix_req = pix_req_q;
  assign pix.pix_idx = pix_idx_q;
  assign led_dout    = led_dout_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Directed bench for a 3-pixel chain: decodes led_dout into bytes and checks them against a scoreboard.
`timescale 1ns/1ps
module tb_ws2812_chain_driver;

  localparam int N     = 3;
  localparam int T_BIT = 50;
  localparam int T0H   = 16;
  localparam int T1H   = 32;
  localparam int T_RES = 4000;
  localparam int IDX_W = 2;

  logic       clk = 1'b0;
  logic       res;
  logic       start;
  logic       auto_refresh;
  logic [7:0] brightness;
  logic       led_dout;
  logic       busy;
  logic       frame_done;

  ws2812_chain_driver_if #(.IDX_W(IDX_W)) pif ();

  ws2812_chain_driver #(
    .NUM_LEDS (N),
    .T_BIT    (T_BIT),
    .T0H      (T0H),
    .T1H      (T1H),
    .T_RES    (T_RES)
  ) dut (
    .clk          (clk),
    .res          (res),
    .start        (start),
    .auto_refresh (auto_refresh),
    .brightness   (brightness),
    .pix          (pif),
    .led_dout     (led_dout),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [N];
  logic [7:0]  sb [$];
  int          errs = 0;
  int          checks = 0;
  int          preq_cnt = 0;

  // Pixel store answers exactly one cycle after the strobe; anything else reads back junk.
  always @(posedge clk) pif.pix_data <= pif.pix_req ? mem[pif.pix_idx] : 24'h5A5A5A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_ch(input logic [7:0] ch, input logic [7:0] b);
    int p;
    p = int'(ch) * (int'(b) + 1);
    return 8'(p >> 8);
  endfunction

  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < N; i++) begin
      sb.push_back(exp_ch(mem[i][23:16], b));
      sb.push_back(exp_ch(mem[i][15:8], b));
      sb.push_back(exp_ch(mem[i][7:0], b));
    end
  endtask

  // Line decoder: rebuilds bytes from high widths and checks every bit period and reset gap.
  logic       prev_led = 1'b0;
  logic       pending = 1'b0;
  int         hi_cnt = 0;
  int         lo_cnt = 0;
  int         last_hi = 0;
  int         nbits = 0;
  logic [7:0] byte_acc = '0;

  always @(negedge clk) begin
    if (pif.pix_req) preq_cnt++;
    if (res) begin
      prev_led = 1'b0;
      pending  = 1'b0;
      hi_cnt   = 0;
      lo_cnt   = 0;
      nbits    = 0;
    end else begin
      if (led_dout) begin
        if (!prev_led) begin
          if (pending) chk("bit_period", last_hi + lo_cnt, T_BIT);
          pending = 1'b0;
          hi_cnt  = 1;
        end else begin
          hi_cnt++;
        end
      end else begin
        if (prev_led) begin
          last_hi = hi_cnt;
          chk("bit_high_width", (hi_cnt == T0H || hi_cnt == T1H), 1'b1);
          byte_acc = {byte_acc[6:0], (hi_cnt == T1H)};
          nbits++;
          if (nbits == 8) begin
            nbits = 0;
            chk("sb_nonempty", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) chk("byte", byte_acc, sb.pop_front());
          end
          lo_cnt  = 1;
          pending = 1'b1;
        end else begin
          lo_cnt++;
        end
      end
      if (frame_done) begin
        chk("res_gap", lo_cnt, T_BIT - last_hi + T_RES);
        chk("frame_bit_align", nbits, 0);
        pending = 1'b0;
      end
      prev_led = led_dout;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (busy && k < max) begin
      step(1);
      k++;
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic wait_fd(input int max);
    int k = 0;
    while (!frame_done && k < max) begin
      step(1);
      k++;
    end
    chk("frame_done_seen", frame_done, 1'b1);
  endtask

  int base;

  initial begin
    res = 1'b1; start = 1'b0; auto_refresh = 1'b0; brightness = 8'd0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    step(3);
    chk("rst_led", led_dout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_req", pif.pix_req, 1'b0);
    chk("rst_idx", pif.pix_idx, 0);
    res = 1'b0;
    step(2);

    // Frame 1: full brightness, exact cycle timing of fetch, first bit, prefetch and reset gap.
    mem[0] = 24'hFF0000; mem[1] = 24'h00C300; mem[2] = 24'h00003C;
    brightness = 8'd255;
    push_frame(8'd255);
    base = preq_cnt;
    start = 1'b1;                                       // cycle n
    chk("idle_busy", busy, 1'b0);
    step(1); start = 1'b0;                              // n+1
    chk("fetch_busy", busy, 1'b1);
    chk("fetch_req", pif.pix_req, 1'b1);
    chk("fetch_idx", pif.pix_idx, 0);
    step(1);                                            // n+2
    chk("load_req", pif.pix_req, 1'b0);
    chk("load_led", led_dout, 1'b0);
    step(1);                                            // n+3
    chk("first_rise", led_dout, 1'b1);
    step(31);                                           // n+34
    chk("bit0_high_last", led_dout, 1'b1);
    step(1);                                            // n+35
    chk("bit0_fall", led_dout, 1'b0);
    step(17);                                           // n+52
    chk("bit0_low_last", led_dout, 1'b0);
    step(1);                                            // n+53
    chk("bit1_rise", led_dout, 1'b1);
    step(1099);                                         // n+1152
    chk("pre1_quiet", pif.pix_req, 1'b0);
    step(1);                                            // n+1153
    chk("pre1_req", pif.pix_req, 1'b1);
    chk("pre1_idx", pif.pix_idx, 1);
    step(1);                                            // n+1154
    chk("pre1_one_cycle", pif.pix_req, 1'b0);
    start = 1'b1;
    step(1); start = 1'b0;                              // n+1155
    chk("start_ignored_busy", busy, 1'b1);
    step(1198);                                         // n+2353
    chk("pre2_req", pif.pix_req, 1'b1);
    chk("pre2_idx", pif.pix_idx, 2);
    step(5248);                                         // n+7601
    chk("res_pre_done", frame_done, 1'b0);
    chk("res_led", led_dout, 1'b0);
    step(1);                                            // n+7602
    chk("done_pulse", frame_done, 1'b1);
    chk("done_busy", busy, 1'b1);
    step(1);                                            // n+7603
    chk("done_single", frame_done, 1'b0);
    chk("busy_fall", busy, 1'b0);
    step(3);
    chk("no_queued_start", busy, 1'b0);
    chk("frame1_req_count", preq_cnt - base, 3);
    chk("frame1_sb_empty", sb.size(), 0);

    // Half brightness; a mid-frame brightness change must not take effect.
    for (int i = 0; i < N; i++) mem[i] = 24'h808080;
    brightness = 8'd127;
    for (int i = 0; i < 3 * N; i++) sb.push_back(8'h40);
    start = 1'b1; step(1); start = 1'b0;
    step(500);
    brightness = 8'd0;
    wait_idle(9000);
    chk("half_sb_empty", sb.size(), 0);

    // Zero brightness on full white: every bit encodes as 0.
    for (int i = 0; i < N; i++) mem[i] = 24'hFFFFFF;
    for (int i = 0; i < 3 * N; i++) sb.push_back(8'h00);
    start = 1'b1; step(1); start = 1'b0;
    wait_idle(9000);
    chk("zero_sb_empty", sb.size(), 0);

    // Auto refresh: back-to-back frames, then stop after the frame in flight.
    mem[0] = 24'hA50000; mem[1] = 24'h00C300; mem[2] = 24'h00003C;
    brightness = 8'd255;
    push_frame(8'd255);
    push_frame(8'd255);
    auto_refresh = 1'b1;
    start = 1'b1; step(1); start = 1'b0;
    wait_fd(9000);
    step(1);
    chk("auto_busy", busy, 1'b1);
    chk("auto_req", pif.pix_req, 1'b1);
    chk("auto_idx", pif.pix_idx, 0);
    step(5);
    auto_refresh = 1'b0;
    wait_fd(9000);
    step(1);
    chk("auto_stop_busy", busy, 1'b0);
    chk("auto_stop_req", pif.pix_req, 1'b0);
    chk("auto_sb_empty", sb.size(), 0);

    // Reset in the middle of pixel 1, then a clean frame.
    push_frame(8'd255);
    start = 1'b1; step(1); start = 1'b0;                // n+1
    step(1204);                                         // n+1205
    chk("mid_led_high", led_dout, 1'b1);
    res = 1'b1;
    step(1);
    chk("mid_rst_led", led_dout, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_req", pif.pix_req, 1'b0);
    step(2);
    res = 1'b0;
    sb.delete();
    step(2);
    push_frame(8'd255);
    base = preq_cnt;
    start = 1'b1; step(1); start = 1'b0;
    wait_idle(9000);
    chk("post_rst_req_count", preq_cnt - base, 3);
    chk("post_rst_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
